// File: rtl/sonar_pkg.sv
// sonar_pkg: shared scheduler state encoding and default ping/angle constants
package sonar_pkg;
  typedef enum logic [1:0] {IDLE, BURST, LISTEN, REPORT} sched_state_t;
  localparam int DEF_BURST_CYCLES = 524288;
  localparam int DEF_PERIOD_CYCLES = 16777216;
  localparam int DEF_ANGLE_WIDTH = 8;
  localparam int DEF_ANGLE_MIN = -30;
  localparam int DEF_ANGLE_MAX = 30;
  localparam int DEF_ANGLE_STEP = 10;
endpackage

// File: rtl/beam_sweep_scheduler_if.sv
// beam_sweep_scheduler_if: control, capture strobes and result bus of the ping sequencer
interface beam_sweep_scheduler_if #(
  parameter int ANGLE_WIDTH = 8
);
  logic                          enable_in;
  logic                          sweep_mode_in;
  logic signed [ANGLE_WIDTH-1:0] fixed_angle_in;
  logic                          tof_valid_in;
  logic [15:0]                   range_in;
  logic                          vel_valid_in;
  logic [15:0]                   velocity_in;
  logic                          towards_in;
  logic                          burst_start_out;
  logic                          tx_active_out;
  logic                          rx_active_out;
  logic signed [ANGLE_WIDTH-1:0] beam_angle_out;
  logic                          busy_out;
  logic                          result_valid_out;
  logic signed [ANGLE_WIDTH-1:0] result_angle_out;
  logic                          result_hit_out;
  logic [15:0]                   result_range_out;
  logic [15:0]                   result_velocity_out;
  logic                          result_towards_out;
  logic                          sweep_done_out;
  modport master (
    output enable_in, sweep_mode_in, fixed_angle_in, tof_valid_in, range_in,
           vel_valid_in, velocity_in, towards_in,
    input  burst_start_out, tx_active_out, rx_active_out, beam_angle_out, busy_out,
           result_valid_out, result_angle_out, result_hit_out, result_range_out,
           result_velocity_out, result_towards_out, sweep_done_out
  );
  modport slave (
    input  enable_in, sweep_mode_in, fixed_angle_in, tof_valid_in, range_in,
           vel_valid_in, velocity_in, towards_in,
    output burst_start_out, tx_active_out, rx_active_out, beam_angle_out, busy_out,
           result_valid_out, result_angle_out, result_hit_out, result_range_out,
           result_velocity_out, result_towards_out, sweep_done_out
  );
endinterface

// File: rtl/ping_timer.sv
// ping_timer: ping cycle counter with synchronous clear and burst/listen terminal flags
module ping_timer
  import sonar_pkg::*;
#(
  parameter int BURST_CYCLES = DEF_BURST_CYCLES,
  parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic burst_last,
  output logic listen_last
);
  localparam int CW = $clog2(PERIOD_CYCLES);
  logic [CW-1:0] cnt;
  // free-running ping counter, restarted at every ping start
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= clr ? '0 : cnt + 1'b1;
  assign burst_last = cnt == CW'(BURST_CYCLES - 1);
  assign listen_last = cnt == CW'(PERIOD_CYCLES - 1);
endmodule

// File: rtl/beam_sweep_scheduler.sv
// beam_sweep_scheduler: sonar ping timeline, beam steering and per-ping result capture
module beam_sweep_scheduler
  import sonar_pkg::*;
#(
  parameter int BURST_CYCLES = DEF_BURST_CYCLES,
  parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int ANGLE_WIDTH = DEF_ANGLE_WIDTH,
  parameter int ANGLE_MIN = DEF_ANGLE_MIN,
  parameter int ANGLE_MAX = DEF_ANGLE_MAX,
  parameter int ANGLE_STEP = DEF_ANGLE_STEP
) (
  input logic clk_in,
  input logic rst_in,
  beam_sweep_scheduler_if.slave bus
);
  localparam logic signed [ANGLE_WIDTH-1:0] A_MIN = ANGLE_WIDTH'(ANGLE_MIN);
  localparam logic signed [ANGLE_WIDTH-1:0] A_MAX = ANGLE_WIDTH'(ANGLE_MAX);
  localparam logic signed [ANGLE_WIDTH-1:0] A_STEP = ANGLE_WIDTH'(ANGLE_STEP);
  sched_state_t state, state_n;
  logic start, listening, report, burst_last, listen_last, sweep_q, wrap;
  logic signed [ANGLE_WIDTH-1:0] clamped, angle_n;
  logic hit_q, hit_n, tow_q, tow_n;
  logic [15:0] range_q, range_n, vel_q, vel_n;
  ping_timer #(
    .BURST_CYCLES(BURST_CYCLES),
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_timer (
    .clk(clk_in),
    .rst(rst_in),
    .clr(start),
    .burst_last(burst_last),
    .listen_last(listen_last)
  );
  // next state, next ping angle and next capture values; result is loaded with the
  // next capture values so a strobe on the last listen cycle still lands in the report
  always_comb begin
    state_n = state == IDLE   ? (bus.enable_in ? BURST : IDLE)
            : state == BURST  ? (burst_last ? LISTEN : BURST)
            : state == LISTEN ? (listen_last ? REPORT : LISTEN)
            : (bus.enable_in ? BURST : IDLE);
    start = state_n == BURST && state != BURST;
    listening = state == LISTEN;
    report = listening && listen_last;
    clamped = bus.fixed_angle_in < A_MIN ? A_MIN
            : bus.fixed_angle_in > A_MAX ? A_MAX : bus.fixed_angle_in;
    wrap = state == IDLE || !sweep_q || bus.beam_angle_out == A_MAX;
    angle_n = !bus.sweep_mode_in ? clamped : wrap ? A_MIN : bus.beam_angle_out + A_STEP;
    hit_n = start ? 1'b0 : hit_q | (listening & bus.tof_valid_in);
    range_n = start ? '0 : (listening && bus.tof_valid_in && !hit_q) ? bus.range_in : range_q;
    vel_n = start ? '0 : (listening && bus.vel_valid_in) ? bus.velocity_in : vel_q;
    tow_n = start ? 1'b0 : (listening && bus.vel_valid_in) ? bus.towards_in : tow_q;
  end
  // state register
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) state <= IDLE;
    else state <= state_n;
  // registered timeline outputs; angle and mode are latched once per ping
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      bus.burst_start_out <= 1'b0;
      bus.tx_active_out <= 1'b0;
      bus.rx_active_out <= 1'b0;
      bus.busy_out <= 1'b0;
      bus.beam_angle_out <= '0;
      sweep_q <= 1'b0;
    end else begin
      bus.burst_start_out <= start;
      bus.tx_active_out <= state_n == BURST;
      bus.rx_active_out <= state_n == LISTEN;
      bus.busy_out <= state_n != IDLE;
      if (start) begin
        bus.beam_angle_out <= angle_n;
        sweep_q <= bus.sweep_mode_in;
      end
    end
  // listen-window capture: first range wins, last velocity wins
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      hit_q <= 1'b0;
      range_q <= '0;
      vel_q <= '0;
      tow_q <= 1'b0;
    end else begin
      hit_q <= hit_n;
      range_q <= range_n;
      vel_q <= vel_n;
      tow_q <= tow_n;
    end
  // result bus, updated once per ping and held until the next report
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      bus.result_valid_out <= 1'b0;
      bus.sweep_done_out <= 1'b0;
      bus.result_angle_out <= '0;
      bus.result_hit_out <= 1'b0;
      bus.result_range_out <= '0;
      bus.result_velocity_out <= '0;
      bus.result_towards_out <= 1'b0;
    end else begin
      bus.result_valid_out <= report;
      bus.sweep_done_out <= report && sweep_q && bus.beam_angle_out == A_MAX;
      if (report) begin
        bus.result_angle_out <= bus.beam_angle_out;
        bus.result_hit_out <= hit_n;
        bus.result_range_out <= range_n;
        bus.result_velocity_out <= vel_n;
        bus.result_towards_out <= tow_n;
      end
    end
endmodule

// File: doc/beam_sweep_scheduler.md
# beam_sweep_scheduler

Top-level ping sequencer for the sonar: it owns the transmit/listen timeline and the beam steering angle. Each ping is a burst window followed by a listen window. It drives `burst_start_out`, `tx_active_out`, `rx_active_out` and `beam_angle_out` to the transmit/receive beamformers, SPI ADC controllers and time counters. It latches the time-of-flight and velocity results produced during the listen window, then publishes one tagged result per ping for the seven-segment display path.

## Interface
- `BURST_CYCLES`, default 524288: length of the transmit window in cycles.
- `PERIOD_CYCLES`, default 16777216: burst plus listen length in cycles; must exceed `BURST_CYCLES`.
- `ANGLE_WIDTH`, default 8: signed width of all angles, in degrees.
- `ANGLE_MIN`, default -30: lowest steering angle.
- `ANGLE_MAX`, default 30: highest steering angle.
- `ANGLE_STEP`, default 10: sweep increment; (`ANGLE_MAX` - `ANGLE_MIN`) must be a multiple of it.

Ports:
- `clk_in`  in  1  system clock, 100 MHz.
- `rst_in`  in  1  asynchronous, active-high reset.
- `enable_in`  in  1  run pings continuously while high.
- `sweep_mode_in`  in  1  1 = sawtooth sweep, 0 = fixed angle.
- `fixed_angle_in`  in  `ANGLE_WIDTH`  signed angle used in fixed mode.
- `tof_valid_in`  in  1  range result strobe.
- `range_in`  in  16  range value qualified by `tof_valid_in`.
- `vel_valid_in`  in  1  velocity result strobe.
- `velocity_in`  in  16  velocity magnitude qualified by `vel_valid_in`.
- `towards_in`  in  1  velocity direction qualified by `vel_valid_in`.
- `burst_start_out`  out  1  one-cycle pulse on the first cycle of every ping.
- `tx_active_out`  out  1  high during the burst window.
- `rx_active_out`  out  1  high during the listen window.
- `beam_angle_out`  out  `ANGLE_WIDTH`  signed angle of the current ping.
- `busy_out`  out  1  high whenever the state is not IDLE.
- `result_valid_out`  out  1  one-cycle pulse when the result bus is updated.
- `result_angle_out`  out  `ANGLE_WIDTH`  angle the result belongs to.
- `result_hit_out`  out  1  a range was captured this ping.
- `result_range_out`  out  16  captured range, 0 if no hit.
- `result_velocity_out`  out  16  captured velocity, 0 if none.
- `result_towards_out`  out  1  captured direction, 0 if none.
- `sweep_done_out`  out  1  pulse coincident with the `result_valid_out` of the `ANGLE_MAX` ping, sweep mode only.

## Operation
- **States:** IDLE, BURST, LISTEN, REPORT. A single cycle counter `cnt` runs across the ping and is cleared on entry to BURST.
- **IDLE → BURST:** when `enable_in` = 1.
- **BURST → LISTEN:** when `cnt` = `BURST_CYCLES`-1.
- **LISTEN → REPORT:** when `cnt` = `PERIOD_CYCLES`-1.
- **REPORT → BURST or IDLE:** REPORT lasts exactly one cycle, then goes to BURST if `enable_in` = 1, else IDLE. `enable_in` low mid-ping does not abort the ping: the ping completes and reports.
- **Ping start (entry to BURST):**
  - `sweep_mode_in` and `fixed_angle_in` are sampled.
  - Fixed mode: the angle is `fixed_angle_in`, clamped to [`ANGLE_MIN`, `ANGLE_MAX`].
  - Sweep mode: the angle is `ANGLE_MIN` if the previous ping was fixed, was `ANGLE_MAX`, or this is the first ping since IDLE. Otherwise it is the previous angle + `ANGLE_STEP`.
  - `beam_angle_out` holds the selected angle for the whole ping.
- **Capture during LISTEN only** (strobes in BURST, REPORT or IDLE are ignored):
  - The first `tof_valid_in` wins: it sets the hit flag and latches `range_in`. Later strobes in the same ping are ignored.
  - The last `vel_valid_in` wins: it latches `velocity_in` and `towards_in`.
  - Capture registers clear on entry to BURST.
- **Result bus:** in REPORT, the captured values and the ping angle are copied to the `result_*` outputs. The bus holds until the next REPORT.
- **Arithmetic:** angle math is signed at `ANGLE_WIDTH`. The clamp compares signed values. `cnt` width is $clog2(`PERIOD_CYCLES`).

## Timing
- **Reset:** all outputs are 0, including `beam_angle_out` (boresight). State is IDLE, `cnt` = 0.
- **Reset asserted mid-ping:** immediate return to IDLE with no result pulse; the sweep position is lost.
- **Control outputs:** all are registered.
  - `burst_start_out` and `tx_active_out` rise on the first BURST cycle, one cycle after `enable_in` is sampled high in IDLE.
  - `tx_active_out` is high for exactly `BURST_CYCLES` cycles.
  - `rx_active_out` is high for exactly `PERIOD_CYCLES` - `BURST_CYCLES` cycles, starting the cycle `tx_active_out` falls.
- **Ping spacing:** back-to-back pings are `PERIOD_CYCLES`+1 cycles apart (REPORT adds one).
- **Last listen cycle:** a strobe on the last LISTEN cycle is captured and appears in that ping's result, one cycle later.
- **Simultaneous strobes:** `tof_valid_in` and `vel_valid_in` in the same cycle are both captured.

## Structure
- **Shared package `sonar_pkg`:** the state enum `sched_state_t`, the default `BURST_CYCLES`/`PERIOD_CYCLES` constants, and the default angle limits. `top_level` shares these constants.
- **Sub-module `ping_timer`:** the counter with a synchronous clear, plus `burst_last` and `listen_last` terminal flags. The FSM, angle stepping and capture logic live in the parent.

## Test plan
All scenarios use `BURST_CYCLES`=4, `PERIOD_CYCLES`=16.
- **Fixed mode:** `enable_in`=1, `sweep_mode_in`=0, `fixed_angle_in`=0 → `burst_start_out` pulses every 17 cycles; `tx_active_out` is high 4 cycles, `rx_active_out` 12; `result_angle_out`=0.
- **Sweep mode:** sweep for 8 pings → angles -30,-20,-10,0,10,20,30,-30; `sweep_done_out` pulses with the +30 result only.
- **Capture:** `tof_valid_in` with range 100 at LISTEN cycle 2 and range 200 at cycle 5; `vel_valid_in` with 7 then 9 → result hit=1, range=100, velocity=9.
- **Ignored and edge strobes:** `tof_valid_in` during BURST, none during LISTEN → hit=0, range=0. `tof_valid_in` on the last LISTEN cycle → hit=1.
- **Clamp and enable:** `fixed_angle_in`=-90 → angle -30. Drop `enable_in` mid-LISTEN → the ping completes, REPORT pulses, then IDLE with `busy_out`=0.
- **Reset mid-ping:** `rst_in` asserted mid-BURST (asynchronously) → all outputs 0 immediately and no `result_valid_out`; after release with sweep enabled, the next ping uses -30.
